scope_trace_renderer: RTL and testbench
=======================================

# scope_trace_renderer

Pixel generator that sits directly downstream of the HDMI timing controller. It consumes the controller's VDEn/hSync/vSync strobes on the pixel clock and reads one captured waveform sample per active column from a synchronous sample RAM. It outputs 24-bit RGB showing a graticule and a continuous trace, plus the timing strobes delayed to stay aligned with the RGB for the TMDS encoder.

## Interface
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- SAMPLE_W, 8: sample width, unsigned.
- ADDR_W, 10: sample RAM address width; requires 2^ADDR_W ≥ H_ACTIVE.
- GRID_X, 64: graticule column spacing in pixels.
- GRID_Y, 60: graticule row spacing in lines.
- pixclk_i  in  1  pixel clock; the only clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- VDEn_i  in  1  active-video enable from the timing controller.
- hSync_i  in  1  horizontal sync, active high.
- vSync_i  in  1  vertical sync, active high.
- smpAddr_o  out  ADDR_W  sample RAM read address.
- smpData_i  in  SAMPLE_W  sample RAM read data, valid one cycle after smpAddr_o.
- rgb_o  out  24  pixel colour, {R,G,B}, 8 bits each.
- VDEn_o  out  1  VDEn_i delayed by the pipeline latency.
- hSync_o  out  1  hSync_i delayed by the pipeline latency.
- vSync_o  out  1  vSync_i delayed by the pipeline latency.
- frameStart_o  out  1  one-cycle pulse on the rising edge of vSync_i; used by capture logic to swap buffers.

## Operation
- Column counter x:
  - cleared while VDEn_i is low; increments each cycle VDEn_i is high.
  - saturates at H_ACTIVE-1.
- Row counter y:
  - cleared on the rising edge of vSync_i.
  - increments on each falling edge of VDEn_i; saturates at V_ACTIVE-1.
- Grid phase counters gx and gy:
  - wrap at GRID_X-1 and GRID_Y-1 respectively; cleared together with x and y.
  - no dividers or modulo operators.
- Pipeline, three stages:
  - S1 registers the inputs and the counters. smpAddr_o = x, registered.
  - S2 registers smpData_i and computes row r = (V_ACTIVE-1) - ((s*V_ACTIVE) >> SAMPLE_W). For s=255 this gives r=1; for s=0, r=479.
  - S3 registers rgb_o and the delayed strobes.
- Trace continuity:
  - prevRow holds r of the previous column. At x=0, prevRow is loaded with the current r.
  - A pixel is trace if min(prevRow, r) ≤ y ≤ max(prevRow, r).
- Colour priority, highest first:
  - VDEn low → 0x000000.
  - trace → 0xFFFF00.
  - grid → 0x404040. Grid is gx==0, gy==0, x==H_ACTIVE-1 or y==V_ACTIVE-1.
  - background → 0x000000.
- Arithmetic: the s*V_ACTIVE product is SAMPLE_W+10 bits unsigned; r and prevRow are 10 bits.

## Timing
- Latency: VDEn_o, hSync_o, vSync_o and rgb_o lag the inputs by exactly 3 cycles, with no bubbles.
- frameStart_o is asserted in the cycle after vSync_i is first sampled high. It is not delayed with the pipeline.
- Reset values: smpAddr_o=0, rgb_o=0, VDEn_o=0, hSync_o=0, vSync_o=0, frameStart_o=0. Counters, prevRow and edge-detect registers are also 0.
- Reset mid-frame:
  - all outputs go to 0 immediately.
  - y restarts at 0 on the first VDEn fall after reset release.
  - geometry is correct from the first vSync rising edge onward.
- Line longer than H_ACTIVE: x holds at H_ACTIVE-1 and the address never exceeds H_ACTIVE-1.
- vSync rising in the same cycle as a VDEn fall: the clear wins, so y=0.
- Sample data is sampled only in S2. RAM write-side timing is the capture block's concern.

## Structure
- Package scope_video_pkg holds:
  - H_ACTIVE, V_ACTIVE and GRID defaults.
  - the colour constants (trace, grid, background).
  - the RGB width.
- Sub-module scope_sample_scaler: sample → row mapping plus the min/max span compare, registered once (this is the S2 stage).
- Counters and edge detects stay in the top level.

## Test plan
- Reset hold then release with no timing → all outputs 0. After 3 cycles of driven timing, outputs track the inputs delayed by 3.
- Full 800x525 frame from the timing controller with RAM all 0x80:
  - trace at row 239 on every column.
  - grid pixels at x=0,64,...,576 and at x=639.
  - VDEn_o count is 307200.
- Ramp RAM, s[x]=x&0xFF → at x=1 the trace spans rows 478..479 only. Consecutive columns form a gap-free span (|Δr| ≤ 2).
- Step sample 0 → 255 between x=99 and x=100 → column 100 lit for rows 1..479 inclusive.
- vSync_i rising → frameStart_o high for exactly 1 cycle; y cleared.
- rst_n_i asserted at line 200, pixel 300 → rgb_o=0 in the same cycle. The next full frame matches the golden model bit-exactly.

Source files
------------

// File: rtl/scope_video_pkg.sv
// Shared geometry defaults and colour constants for the scope trace renderer.
package scope_video_pkg;

  // Default active geometry and graticule spacing.
  localparam int unsigned HActive = 640;
  localparam int unsigned VActive = 480;
  localparam int unsigned GridX   = 64;
  localparam int unsigned GridY   = 60;

  // Row numbers (y, r, prevRow) are always this wide.
  localparam int unsigned RowW = 10;

  // Pixel format is {R,G,B}, 8 bits per channel.
  localparam int unsigned RgbW = 24;

  localparam logic [RgbW-1:0] ColTrace = 24'hFFFF00;
  localparam logic [RgbW-1:0] ColGrid  = 24'h404040;
  localparam logic [RgbW-1:0] ColBg    = 24'h000000;

endpackage

// File: rtl/scope_sample_scaler.sv
// S2 stage: maps a sample to a screen row and decides whether the current
// pixel lies on the trace span joining the previous column to this one.
module scope_sample_scaler
  import scope_video_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned V_ACTIVE = VActive
) (
  input  logic                pixclk_i,
  input  logic                rst_n_i,
  input  logic                vde_i,
  input  logic                first_col_i,
  input  logic [RowW-1:0]     y_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                trace_o
);

  localparam int unsigned ProdW = SAMPLE_W + RowW;

  logic [ProdW-1:0] prod;
  logic [RowW-1:0]  row;
  logic [RowW-1:0]  prev_row;
  logic [RowW-1:0]  lo;
  logic [RowW-1:0]  hi;
  logic [RowW-1:0]  prev_row_d, prev_row_q;
  logic             trace_d, trace_q;

  // Row mapping (large samples sit near the top) and span compare.
  always_comb begin
    prod     = ProdW'(sample_i) * ProdW'(V_ACTIVE);
    row      = RowW'(V_ACTIVE - 1) - prod[SAMPLE_W +: RowW];
    // Column 0 has no left neighbour, so the span collapses to its own row.
    prev_row = first_col_i ? row : prev_row_q;
    if (prev_row < row) begin
      lo = prev_row;
      hi = row;
    end else begin
      lo = row;
      hi = prev_row;
    end
    trace_d    = (y_i >= lo) && (y_i <= hi);
    prev_row_d = vde_i ? row : prev_row_q;
  end

  // Register the trace decision and remember this column's row.
  always_ff @(posedge pixclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_row_q <= '0;
      trace_q    <= 1'b0;
    end else begin
      prev_row_q <= prev_row_d;
      trace_q    <= trace_d;
    end
  end

  assign trace_o = trace_q;

endmodule

// File: rtl/scope_trace_renderer.sv
// Oscilloscope pixel generator: graticule plus continuous waveform trace,
// with timing strobes delayed three cycles to stay aligned with the RGB.
module scope_trace_renderer
  import scope_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActive,
  parameter int unsigned V_ACTIVE = VActive,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned GRID_X   = GridX,
  parameter int unsigned GRID_Y   = GridY
) (
  input  logic                pixclk_i,
  input  logic                rst_n_i,
  input  logic                VDEn_i,
  input  logic                hSync_i,
  input  logic                vSync_i,
  output logic [ADDR_W-1:0]   smpAddr_o,
  input  logic [SAMPLE_W-1:0] smpData_i,
  output logic [RgbW-1:0]     rgb_o,
  output logic                VDEn_o,
  output logic                hSync_o,
  output logic                vSync_o,
  output logic                frameStart_o
);

  localparam int unsigned GxW = (GRID_X > 1) ? $clog2(GRID_X) : 1;
  localparam int unsigned GyW = (GRID_Y > 1) ? $clog2(GRID_Y) : 1;

  localparam logic [ADDR_W-1:0] XMax  = ADDR_W'(H_ACTIVE - 1);
  localparam logic [RowW-1:0]   YMax  = RowW'(V_ACTIVE - 1);
  localparam logic [GxW-1:0]    GxMax = GxW'(GRID_X - 1);
  localparam logic [GyW-1:0]    GyMax = GyW'(GRID_Y - 1);

  // Counters: each holds the coordinate of the pixel presented this cycle.
  logic [ADDR_W-1:0] x_d, x_q;
  logic [RowW-1:0]   y_d, y_q;
  logic [GxW-1:0]    gx_d, gx_q;
  logic [GyW-1:0]    gy_d, gy_q;

  // Edge detectors.
  logic vde_prev_q, vs_prev_q, frame_start_q;
  logic vde_fall, vs_rise;

  // S1 pipeline registers.
  logic            s1_vde_q, s1_hs_q, s1_vs_q, s1_first_col_q, s1_grid_q;
  logic [RowW-1:0] s1_y_q;
  logic            s1_grid_d;

  // S2 pipeline registers (trace bit is registered inside the scaler).
  logic s2_vde_q, s2_hs_q, s2_vs_q, s2_grid_q;
  logic s2_trace;

  // S3 output registers.
  logic [RgbW-1:0] rgb_d, rgb_q;
  logic            vde_o_q, hs_o_q, vs_o_q;

  // Next-state for the column/row counters and their graticule phases.
  always_comb begin
    vde_fall = ~VDEn_i & vde_prev_q;
    vs_rise  = vSync_i & ~vs_prev_q;

    x_d  = x_q;
    gx_d = gx_q;
    if (!VDEn_i) begin
      x_d  = '0;
      gx_d = '0;
    end else if (x_q != XMax) begin
      // Phase only advances with x so gx==0 always marks a grid column.
      x_d  = x_q + ADDR_W'(1);
      gx_d = (gx_q == GxMax) ? '0 : gx_q + GxW'(1);
    end

    y_d  = y_q;
    gy_d = gy_q;
    // A vSync rise beats a simultaneous VDEn fall.
    if (vs_rise) begin
      y_d  = '0;
      gy_d = '0;
    end else if (vde_fall && (y_q != YMax)) begin
      y_d  = y_q + RowW'(1);
      gy_d = (gy_q == GyMax) ? '0 : gy_q + GyW'(1);
    end

    s1_grid_d = (gx_q == '0) || (gy_q == '0) || (x_q == XMax) || (y_q == YMax);
  end

  // Counters, edge detectors and the frame-start pulse.
  always_ff @(posedge pixclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_q           <= '0;
      y_q           <= '0;
      gx_q          <= '0;
      gy_q          <= '0;
      vde_prev_q    <= 1'b0;
      vs_prev_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      gx_q          <= gx_d;
      gy_q          <= gy_d;
      vde_prev_q    <= VDEn_i;
      vs_prev_q     <= vSync_i;
      frame_start_q <= vs_rise;
    end
  end

  // S1: capture strobes and per-pixel geometry while the RAM is read.
  always_ff @(posedge pixclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vde_q       <= 1'b0;
      s1_hs_q        <= 1'b0;
      s1_vs_q        <= 1'b0;
      s1_first_col_q <= 1'b0;
      s1_grid_q      <= 1'b0;
      s1_y_q         <= '0;
    end else begin
      s1_vde_q       <= VDEn_i;
      s1_hs_q        <= hSync_i;
      s1_vs_q        <= vSync_i;
      s1_first_col_q <= (x_q == '0);
      s1_grid_q      <= s1_grid_d;
      s1_y_q         <= y_q;
    end
  end

  scope_sample_scaler #(
    .SAMPLE_W (SAMPLE_W),
    .V_ACTIVE (V_ACTIVE)
  ) u_scaler (
    .pixclk_i    (pixclk_i),
    .rst_n_i     (rst_n_i),
    .vde_i       (s1_vde_q),
    .first_col_i (s1_first_col_q),
    .y_i         (s1_y_q),
    .sample_i    (smpData_i),
    .trace_o     (s2_trace)
  );

  // S2: carry strobes and grid flag alongside the scaler result.
  always_ff @(posedge pixclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_vde_q  <= 1'b0;
      s2_hs_q   <= 1'b0;
      s2_vs_q   <= 1'b0;
      s2_grid_q <= 1'b0;
    end else begin
      s2_vde_q  <= s1_vde_q;
      s2_hs_q   <= s1_hs_q;
      s2_vs_q   <= s1_vs_q;
      s2_grid_q <= s1_grid_q;
    end
  end

  // Colour priority: blanking, trace, grid, background.
  always_comb begin
    rgb_d = ColBg;
    if (!s2_vde_q) begin
      rgb_d = ColBg;
    end else if (s2_trace) begin
      rgb_d = ColTrace;
    end else if (s2_grid_q) begin
      rgb_d = ColGrid;
    end
  end

  // S3: registered outputs.
  always_ff @(posedge pixclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rgb_q   <= '0;
      vde_o_q <= 1'b0;
      hs_o_q  <= 1'b0;
      vs_o_q  <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      vde_o_q <= s2_vde_q;
      hs_o_q  <= s2_hs_q;
      vs_o_q  <= s2_vs_q;
    end
  end

  assign smpAddr_o    = x_q;
  assign rgb_o        = rgb_q;
  assign VDEn_o       = vde_o_q;
  assign hSync_o      = hs_o_q;
  assign vSync_o      = vs_o_q;
  assign frameStart_o = frame_start_q;

endmodule

// File: tb/tb_scope_trace_renderer.sv
// Scoreboard bench for scope_trace_renderer on a reduced raster.
module tb_scope_trace_renderer;

  localparam int H  = 48;
  localparam int V  = 64;
  localparam int GX = 16;
  localparam int GY = 16;
  localparam int HB = 12;
  localparam int VB = 4;
  localparam int ABORT_LN = 20;
  localparam int ABORT_PX = 30;

  typedef struct {
    int          due;
    logic [26:0] exp;
    logic [26:0] mask;
  } pix_t;

  typedef struct {
    int   due;
    logic exp;
  } fs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vde, hs, vs;
  logic [9:0]  addr;
  logic [7:0]  sdata;
  logic [23:0] rgb;
  logic        vde_o, hs_o, vs_o, fs_o;

  logic [7:0]  ram [1024];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rst_hold = 0;
  bit   vs_prev_m = 0;
  bit   geom_ok = 0;
  bit   abort_armed = 0;
  pix_t pq[$];
  fs_t  fq[$];

  scope_trace_renderer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .SAMPLE_W (8),
    .ADDR_W   (10),
    .GRID_X   (GX),
    .GRID_Y   (GY)
  ) dut (
    .pixclk_i     (clk),
    .rst_n_i      (rst_n),
    .VDEn_i       (vde),
    .hSync_i      (hs),
    .vSync_i      (vs),
    .smpAddr_o    (addr),
    .smpData_i    (sdata),
    .rgb_o        (rgb),
    .VDEn_o       (vde_o),
    .hSync_o      (hs_o),
    .vSync_o      (vs_o),
    .frameStart_o (fs_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous sample RAM: data one cycle after the address.
  always @(posedge clk) sdata <= ram[addr];

  function automatic int row_of(input logic [7:0] s);
    return (V - 1) - ((int'(s) * V) >> 8);
  endfunction

  // Colour of active pixel (h, ln) from the picture rules.
  function automatic logic [23:0] exp_rgb(input int h, input int ln);
    int xe, xp, rc, rp, lo, hi;
    xe = (h > H - 1) ? H - 1 : h;
    xp = (h == 0) ? xe : ((h - 1 > H - 1) ? H - 1 : h - 1);
    rc = row_of(ram[xe]);
    rp = row_of(ram[xp]);
    lo = (rc < rp) ? rc : rp;
    hi = (rc < rp) ? rp : rc;
    if (ln >= lo && ln <= hi) return 24'hFFFF00;
    if ((xe % GX == 0) || (ln % GY == 0) || (xe == H - 1) || (ln == V - 1)) return 24'h404040;
    return 24'h000000;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // One pixel clock of stimulus; pushes the expected response.
  task automatic drive(input bit v, input bit h_s, input bit v_s, input int h, input int ln);
    pix_t p;
    fs_t  f;
    bit   in_rst, fs;
    if (!rst_n) begin
      if (rst_hold == 0) rst_n = 1'b1;
      else rst_hold--;
    end
    vde = v;
    hs  = h_s;
    vs  = v_s;
    in_rst    = !rst_n;
    fs        = !in_rst && v_s && !vs_prev_m;
    vs_prev_m = in_rst ? 1'b0 : v_s;
    if (in_rst) geom_ok = 0;
    else if (fs) geom_ok = 1;
    p.due = cyc + 3;
    f.due = cyc + 1;
    f.exp = fs;
    if (in_rst) begin
      p.exp  = '0;
      p.mask = '1;
    end else if (!v) begin
      p.exp  = {v, h_s, v_s, 24'h0};
      p.mask = '1;
    end else if (geom_ok) begin
      p.exp  = {v, h_s, v_s, exp_rgb(h, ln)};
      p.mask = '1;
    end else begin
      p.exp  = {v, h_s, v_s, 24'h0};
      p.mask = {3'b111, 24'h0};
    end
    pq.push_back(p);
    fq.push_back(f);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rst_hold = 3;
    pq.delete();
    fq.delete();
    abort_armed = 0;
    #1;
    check("midreset_rgb", 64'(rgb), 64'h0);
    check("midreset_strobes", 64'({vde_o, hs_o, vs_o, fs_o, addr}), 64'h0);
  endtask

  task automatic run_line(input int n_act, input int ln, input bit vs_act, input bit vs_blk);
    for (int h = 0; h < n_act; h++) begin
      if (abort_armed && ln == ABORT_LN && h == ABORT_PX) do_reset();
      drive(1'b1, 1'b0, vs_act, h, ln);
    end
    for (int b = 0; b < HB; b++) drive(1'b0, (b >= 3 && b < 7), vs_blk, 0, ln);
  endtask

  task automatic run_vblank(input bit corner);
    for (int l = 0; l < VB; l++) begin
      run_line(0, 0, corner ? (l < 2) : (l == 1), corner ? (l < 2) : (l == 1));
    end
  endtask

  // corner: vSync rises on the very cycle the last active line ends.
  task automatic run_frame(input int extra, input bit corner);
    for (int ln = 0; ln < V; ln++) run_line(H + extra, ln, 1'b0, corner && (ln == V - 1));
    run_vblank(corner);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom_range(0, 255));
  endtask

  // Monitor: compares DUT outputs against the scoreboard each cycle.
  initial begin
    pix_t        e;
    fs_t         f;
    logic [26:0] act;
    forever begin
      @(negedge clk);
      while (pq.size() > 0 && pq[0].due < cyc) void'(pq.pop_front());
      while (fq.size() > 0 && fq[0].due < cyc) void'(fq.pop_front());
      if (pq.size() > 0 && pq[0].due == cyc) begin
        e   = pq.pop_front();
        act = {vde_o, hs_o, vs_o, rgb};
        checks++;
        if ((act & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL pix cyc=%0d got %h want %h mask %h", cyc, act, e.exp, e.mask);
        end
      end
      if (fq.size() > 0 && fq[0].due == cyc) begin
        f = fq.pop_front();
        checks++;
        if (fs_o !== f.exp) begin
          errors++;
          $display("FAIL frameStart cyc=%0d got %b want %b", cyc, fs_o, f.exp);
        end
      end
      if (rst_n) begin
        checks++;
        if (addr > 10'(H - 1)) begin
          errors++;
          $display("FAIL addr_range cyc=%0d got %0d want <= %0d", cyc, addr, H - 1);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    vde   = 1'b0;
    hs    = 1'b0;
    vs    = 1'b0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", 64'(rgb), 64'h0);
    check("reset_outs", 64'({vde_o, hs_o, vs_o, fs_o, addr}), 64'h0);

    rst_hold = 4;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 0, 0);
    run_vblank(1'b0);

    for (int i = 0; i < 1024; i++) ram[i] = 8'h80;
    run_frame(0, 1'b0);

    for (int i = 0; i < 1024; i++) ram[i] = 8'((i * 5) & 255);
    run_frame(0, 1'b0);

    for (int i = 0; i < 1024; i++) ram[i] = (i < 20) ? 8'h00 : 8'hFF;
    run_frame(0, 1'b0);

    fill_random();
    run_frame(6, 1'b0);

    fill_random();
    run_frame(0, 1'b1);

    fill_random();
    run_frame(0, 1'b0);

    fill_random();
    abort_armed = 1;
    run_frame(0, 1'b0);

    fill_random();
    run_frame(0, 1'b0);

    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
